// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 16-bit CPU words, 4-word lines.
// Hits complete combinationally. A miss first evicts a dirty victim line, then fills.
//
// state | meaning
// IDLE  | serve hits in the request cycle, classify misses
// EVICT | drive dirty victim line to memory, cnt 0..4
// FILL  | fetch requested line from memory, cnt 0..4
module dcache_direct_wb #(
  parameter int NUM_LINES  = 4,
  parameter int WORD_SIZE  = 16,
  parameter int FETCH_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [15:0]           cpu_address,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_ready,
  output logic                  d_readM,
  output logic                  d_writeM,
  output logic [15:0]           d_addressM,
  inout  wire  [FETCH_SIZE-1:0] d_dataM,
  output logic [15:0]           access_count,
  output logic [15:0]           miss_count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 16 - INDEX_W - 2;
  localparam int WORDS   = FETCH_SIZE / WORD_SIZE;

  typedef enum logic [1:0] {IDLE, EVICT, FILL} stateT;

  stateT                         state, stateNext;
  logic [2:0]                    cnt, cntNext;
  logic [NUM_LINES-1:0]          validBits, dirtyBits;
  logic [TAG_W-1:0]              tagMem  [NUM_LINES];
  logic [WORDS-1:0][WORD_SIZE-1:0] dataMem [NUM_LINES];

  logic [INDEX_W-1:0] reqIdx, missIdx;
  logic [TAG_W-1:0]   reqTag, missTag;
  logic [1:0]         reqOff;
  logic               request, hit, lastBeat;
  logic               missStart, writeHit, fillDone, evictDone;

  assign reqOff  = cpu_address[1:0];
  assign reqIdx  = cpu_address[INDEX_W+1:2];
  assign reqTag  = cpu_address[15:INDEX_W+2];
  assign request = cpu_read | cpu_write;
  assign hit     = request && validBits[reqIdx] && (tagMem[reqIdx] == reqTag);
  assign lastBeat = (cnt == 3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Miss slot and tag are latched so a misbehaving CPU cannot steer the fill into another line.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    cpu_ready  = 1'b0;
    d_readM    = 1'b0;
    d_writeM   = 1'b0;
    d_addressM = '0;
    missStart  = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (hit) begin
            cpu_ready = 1'b1;
          end else begin
            missStart = 1'b1;
            cntNext   = 3'd0;
            stateNext = (validBits[reqIdx] && dirtyBits[reqIdx]) ? EVICT : FILL;
          end
        end
      end
      EVICT: begin
        d_writeM   = (cnt == 3'd0);
        d_addressM = {tagMem[missIdx], missIdx, 2'b00};
        if (lastBeat) begin
          stateNext = FILL;
          cntNext   = 3'd0;
        end else begin
          cntNext = cnt + 3'd1;
        end
      end
      FILL: begin
        d_readM    = (cnt == 3'd0);
        d_addressM = {missTag, missIdx, 2'b00};
        if (lastBeat) begin
          stateNext = IDLE;
          cntNext   = 3'd0;
        end else begin
          cntNext = cnt + 3'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 3'd0;
      end
    endcase
  end

  assign writeHit  = cpu_ready && cpu_write;
  assign fillDone  = (state == FILL) && lastBeat;
  assign evictDone = (state == EVICT) && lastBeat;

  assign cpu_rdata = (cpu_ready && cpu_read && !cpu_write) ? dataMem[reqIdx][reqOff] : '0;
  assign d_dataM   = (state == EVICT) ? dataMem[missIdx] : {FETCH_SIZE{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validBits    <= '0;
      dirtyBits    <= '0;
      missIdx      <= '0;
      missTag      <= '0;
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      if (cpu_ready) access_count <= access_count + 16'd1;
      if (missStart) begin
        miss_count <= miss_count + 16'd1;
        missIdx    <= reqIdx;
        missTag    <= reqTag;
      end
      if (writeHit)  dirtyBits[reqIdx]  <= 1'b1;
      if (evictDone) dirtyBits[missIdx] <= 1'b0;
      if (fillDone) begin
        validBits[missIdx] <= 1'b1;
        dirtyBits[missIdx] <= 1'b0;
      end
    end
  end

  // Line storage needs no reset: validBits gates every use of it.
  always_ff @(posedge clk) begin
    if (writeHit) dataMem[reqIdx][reqOff] <= cpu_wdata;
    if (fillDone) begin
      dataMem[missIdx] <= d_dataM;
      tagMem[missIdx]  <= missTag;
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Bench for dcache_direct_wb: 4-cycle line memory, spec vector table, reset abort, and
// randomized accesses checked against a coherent-view reference model.
module tb_dcache_direct_wb;

  logic        clk;
  logic        reset_n, cpu_read, cpu_write;
  logic [15:0] cpu_address, cpu_wdata, cpu_rdata, d_addressM, access_count, miss_count;
  logic        cpu_ready, d_readM, d_writeM;
  wire  [63:0] d_dataM;

  localparam logic [63:0] RELEASED = '1;

  dcache_direct_wb #(.NUM_LINES(4), .WORD_SIZE(16), .FETCH_SIZE(64)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .d_readM(d_readM), .d_writeM(d_writeM),
    .d_addressM(d_addressM), .d_dataM(d_dataM),
    .access_count(access_count), .miss_count(miss_count)
  );

  // An undriven bus reads as all ones.
  pullup (d_dataM);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] initVal(input int a);
    case (a)
      0: return 16'h9023;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return (a < 64) ? 16'h0000 : (16'(a * 797) ^ 16'hC35A);
    endcase
  endfunction

  // Memory: read strobe -> FETCH0..3, line on bus during FETCH3; write strobe -> STORE0..3, commit at end of STORE3.
  logic [15:0] mem [256];
  logic        memLoad;
  logic [2:0]  rdPhase, wrPhase;
  logic [7:0]  rdBase, wrBase;

  always @(posedge clk) begin
    if (memLoad) begin
      for (int a = 0; a < 256; a++) mem[a] <= initVal(a);
    end
    if (!reset_n) begin
      rdPhase <= 3'd0;
      wrPhase <= 3'd0;
    end else begin
      if (d_readM) begin
        rdPhase <= 3'd1;
        rdBase  <= d_addressM[7:0];
      end else if (rdPhase == 3'd4) rdPhase <= 3'd0;
      else if (rdPhase != 3'd0) rdPhase <= rdPhase + 3'd1;
      if (d_writeM) begin
        wrPhase <= 3'd1;
        wrBase  <= d_addressM[7:0];
      end else if (wrPhase == 3'd4) begin
        for (int i = 0; i < 4; i++) mem[wrBase + 8'(i)] <= d_dataM[16*i +: 16];
        wrPhase <= 3'd0;
      end else if (wrPhase != 3'd0) wrPhase <= wrPhase + 3'd1;
    end
  end

  assign d_dataM = (rdPhase == 3'd4) ?
    {mem[rdBase + 8'd3], mem[rdBase + 8'd2], mem[rdBase + 8'd1], mem[rdBase]} : 64'bz;

  // Reference model: refView is what the CPU must observe, refBack is backing memory.
  logic [15:0] refView [256];
  logic [15:0] refBack [256];
  logic        refValid [4];
  logic        refDirty [4];
  logic [11:0] refTag [4];
  int          refAcc, refMiss;
  int          nTests, nFail;

  logic [15:0] lastRdAddr, lastWrAddr, lastRdata;
  logic [63:0] lastWrData;
  int          lastLat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int a = 0; a < 256; a++) refView[a] = refBack[a];
    for (int l = 0; l < 4; l++) begin
      refValid[l] = 1'b0;
      refDirty[l] = 1'b0;
      refTag[l]   = '0;
    end
    refAcc  = 0;
    refMiss = 0;
  endtask

  // Caller sits 1 time unit after a rising edge; returns at the same phase after completion.
  task automatic doAccess(input logic wr, input logic both, input logic [15:0] addr, input logic [15:0] wd);
    int          idx, expLat, fs, c;
    logic [11:0] tag;
    logic [15:0] vBase, lBase, expRd;
    logic [63:0] vLine;
    bit          miss, dirty, done;
    idx   = int'(addr[3:2]);
    tag   = addr[15:4];
    miss  = !(refValid[idx] && refTag[idx] == tag);
    dirty = miss && refValid[idx] && refDirty[idx];
    vBase = {refTag[idx], addr[3:2], 2'b00};
    lBase = {addr[15:2], 2'b00};
    vLine = {refView[vBase[7:0] + 8'd3], refView[vBase[7:0] + 8'd2],
             refView[vBase[7:0] + 8'd1], refView[vBase[7:0]]};
    expLat = !miss ? 0 : (dirty ? 11 : 6);
    fs     = dirty ? 6 : 1;
    if (miss) begin
      refMiss++;
      if (dirty) for (int i = 0; i < 4; i++) refBack[vBase[7:0] + 8'(i)] = refView[vBase[7:0] + 8'(i)];
      refValid[idx] = 1'b1;
      refTag[idx]   = tag;
      refDirty[idx] = 1'b0;
    end
    expRd = refView[addr[7:0]];
    if (wr) begin
      refView[addr[7:0]] = wd;
      refDirty[idx]      = 1'b1;
    end
    refAcc++;

    cpu_address = addr;
    cpu_wdata   = wd;
    cpu_write   = wr;
    cpu_read    = !wr || both;
    lastRdAddr  = 16'hDEAD;
    lastWrAddr  = 16'hDEAD;
    lastWrData  = '0;
    lastLat     = -1;
    done        = 0;
    c           = 0;
    while (!done && c < 16) begin
      @(negedge clk);
      check("d_readM pulse", d_readM, (miss && c == fs));
      check("d_writeM pulse", d_writeM, (dirty && c == 1));
      if (dirty && c >= 1 && c <= 5) begin
        check("evict address", d_addressM, vBase);
        check("evict line", d_dataM, vLine);
      end else if (miss && c >= fs && c <= fs + 4) begin
        check("fill address", d_addressM, lBase);
      end else begin
        check("idle address", d_addressM, 16'h0000);
        check("bus released", d_dataM, RELEASED);
      end
      if (d_readM)  lastRdAddr = d_addressM;
      if (d_writeM) begin
        lastWrAddr = d_addressM;
        lastWrData = d_dataM;
      end
      if (cpu_ready) begin
        done      = 1;
        lastLat   = c;
        lastRdata = cpu_rdata;
      end else begin
        check("rdata while not ready", cpu_rdata, 16'h0000);
      end
      @(posedge clk);
      #1;
      c++;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check("ready within budget", done, 1'b1);
    check("latency", lastLat, expLat);
    if (!wr) check("read data", lastRdata, expRd);
    check("access_count", access_count, 16'(refAcc));
    check("miss_count", miss_count, 16'(refMiss));
  endtask

  task automatic idleCycle();
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    cpu_address = 16'($urandom);
    @(negedge clk);
    check("idle ready", cpu_ready, 1'b0);
    check("idle rdata", cpu_rdata, 16'h0000);
    check("idle strobes", {d_readM, d_writeM}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr, wdata, expRdata;
    int          expLat;
    logic [15:0] expMiss, expAcc, expRdAddr, expWrAddr;
    logic [63:0] expWrData;
  } vecT;

  function automatic vecT mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] expRdata, input int expLat,
                             input logic [15:0] expMiss, input logic [15:0] expAcc,
                             input logic [15:0] expRdAddr, input logic [15:0] expWrAddr,
                             input logic [63:0] expWrData);
    vecT v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.expRdata = expRdata; v.expLat = expLat;
    v.expMiss = expMiss; v.expAcc = expAcc; v.expRdAddr = expRdAddr;
    v.expWrAddr = expWrAddr; v.expWrData = expWrData;
    return v;
  endfunction

  vecT vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr, prevAddr;
    logic        wr, both;
    nTests = 0;
    nFail  = 0;
    vecs[0] = mk(0, 16'h0002, 16'h0000, 16'hFFFF,  6, 1, 1, 16'h0000, 16'h0000, 64'h0);
    vecs[1] = mk(0, 16'h0001, 16'h0000, 16'h0001,  0, 1, 2, 16'h0000, 16'h0000, 64'h0);
    vecs[2] = mk(1, 16'h0003, 16'hABCD, 16'h0000,  0, 1, 3, 16'h0000, 16'h0000, 64'h0);
    vecs[3] = mk(0, 16'h0003, 16'h0000, 16'hABCD,  0, 1, 4, 16'h0000, 16'h0000, 64'h0);
    vecs[4] = mk(0, 16'h0010, 16'h0000, 16'h0000, 11, 2, 5, 16'h0010, 16'h0000, 64'hABCD_FFFF_0001_9023);
    vecs[5] = mk(0, 16'h0003, 16'h0000, 16'hABCD,  6, 3, 6, 16'h0000, 16'h0000, 64'h0);
    vecs[6] = mk(1, 16'h0025, 16'h1234, 16'h0000,  6, 4, 7, 16'h0024, 16'h0000, 64'h0);
    vecs[7] = mk(0, 16'h0025, 16'h0000, 16'h1234,  0, 4, 8, 16'h0000, 16'h0000, 64'h0);
    vecs[8] = mk(0, 16'h0005, 16'h0000, 16'h0000, 11, 5, 9, 16'h0004, 16'h0024, 64'h0000_0000_1234_0000);

    reset_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_wdata = '0; memLoad = 1'b1;
    for (int a = 0; a < 256; a++) refBack[a] = initVal(a);
    modelReset();
    repeat (2) @(posedge clk);
    #1 memLoad = 1'b0;
    check("reset ready", cpu_ready, 1'b0);
    check("reset rdata", cpu_rdata, 16'h0000);
    check("reset strobes", {d_readM, d_writeM}, 2'b00);
    check("reset address", d_addressM, 16'h0000);
    check("reset bus", d_dataM, RELEASED);
    check("reset counters", {access_count, miss_count}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      doAccess(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d latency", i), lastLat, vecs[i].expLat);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), lastRdata, vecs[i].expRdata);
      check($sformatf("vec%0d miss_count", i), miss_count, vecs[i].expMiss);
      check($sformatf("vec%0d access_count", i), access_count, vecs[i].expAcc);
      if (vecs[i].expLat > 0) check($sformatf("vec%0d fill addr", i), lastRdAddr, vecs[i].expRdAddr);
      if (vecs[i].expLat == 11) begin
        check($sformatf("vec%0d evict addr", i), lastWrAddr, vecs[i].expWrAddr);
        check($sformatf("vec%0d evict data", i), lastWrData, vecs[i].expWrData);
      end
    end

    // Reset while the FILL for 0x0030 sits at cnt = 2.
    cpu_address = 16'h0030;
    cpu_read    = 1'b1;
    cpu_write   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid-fill address", d_addressM, 16'h0030);
    check("mid-fill strobe", d_readM, 1'b0);
    reset_n = 1'b0;
    #1;
    check("abort strobes", {d_readM, d_writeM}, 2'b00);
    check("abort address", d_addressM, 16'h0000);
    check("abort bus", d_dataM, RELEASED);
    check("abort ready", cpu_ready, 1'b0);
    check("abort counters", {access_count, miss_count}, 32'h0);
    cpu_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    doAccess(1'b0, 1'b0, 16'h0030, 16'h0000);
    check("post-reset miss latency", lastLat, 6);
    check("miss_count restarts", miss_count, 16'h0001);
    doAccess(1'b0, 1'b0, 16'h0003, 16'h0000);
    check("written-back word survives reset", lastRdata, 16'hABCD);

    prevAddr = 16'h0003;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idleCycle();
      end else begin
        wr   = ($urandom_range(0, 2) == 0);
        both = wr && ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 0) addr = {prevAddr[15:2], 2'($urandom_range(0, 3))};
        else addr = 16'($urandom_range(0, 255));
        doAccess(wr, both, addr, 16'($urandom));
        prevAddr = addr;
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dcache_direct_wb.md
# dcache_direct_wb

Direct-mapped, write-back, write-allocate data cache placed between the CPU data port and the D-side port of the 4-cycle, 64-bit-line memory. CPU accesses are 16-bit words. Hits complete in the request cycle. Misses fetch a 4-word line, and first write back a dirty victim line if one occupies the slot. Hit/miss counters are exposed for performance measurement.

## Interface
- NUM_LINES, 4: number of cache lines, a power of two ≥2. INDEX_W = log2(NUM_LINES).
- WORD_SIZE, 16: CPU word width.
- FETCH_SIZE, 64: line width, fixed at 4 words.
- clk  in  1  Single clock; all state updates on the rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- cpu_read  in  1  Read request; held until cpu_ready.
- cpu_write  in  1  Write request; held until cpu_ready. Takes priority if cpu_read is also high.
- cpu_address  in  16  Word address. Offset = [1:0], index = [INDEX_W+1:2], tag = [15:INDEX_W+2].
- cpu_wdata  in  16  Write data.
- cpu_rdata  out  16  Read data, valid while cpu_ready && cpu_read.
- cpu_ready  out  1  Combinational. High in the cycle a request completes.
- d_readM  out  1  Memory line-read strobe.
- d_writeM  out  1  Memory line-write strobe.
- d_addressM  out  16  Line-aligned address, with [1:0] = 0.
- d_dataM  inout  64  Line bus. Driven by the cache only during EVICT; high-Z otherwise. Word i sits at bits [16i+15:16i].
- access_count  out  16  Completed CPU accesses, modulo 2^16.
- miss_count  out  16  Misses detected, modulo 2^16.

## Operation
- Per-line storage: valid, dirty, tag, and 64-bit data.
- FSM states:
  - IDLE
    - Hit = request && valid[idx] && tag match.
    - Read hit: cpu_rdata = word at the offset; cpu_ready = 1.
    - Write hit: cpu_ready = 1. At the edge, write the word and set dirty = 1.
    - Miss with a clean or invalid line: miss_count += 1; go to FILL with cnt = 0.
    - Miss with a dirty line: miss_count += 1; go to EVICT with cnt = 0.
    - No request: cpu_ready = 0.
  - EVICT (cnt 0..4)
    - d_writeM = 1 only at cnt = 0.
    - d_addressM = {stored tag, idx, 2'b00}, held for cnt 0..4.
    - d_dataM = stored line, driven for cnt 0..4. Memory commits at the edge ending cnt = 4.
    - At cnt = 4: dirty[idx] = 0; go to FILL with cnt = 0.
  - FILL (cnt 0..4)
    - d_readM = 1 only at cnt = 0.
    - d_addressM = {request tag, idx, 2'b00}, held for cnt 0..4.
    - At the edge ending cnt = 4, capture d_dataM and set line data, tag, valid = 1, dirty = 0; go to IDLE.
- After FILL the held request re-evaluates in IDLE as a hit. A write miss therefore completes as a write hit and sets dirty.
- access_count increments at each edge where cpu_ready = 1.
- miss_count increments on the IDLE→EVICT/FILL transition only. The retry hit after a fill is not counted as a miss.
- Memory strobes are single-cycle pulses. Holding a strobe high would make memory restart a transaction.
- A CPU request that changes address or type mid-miss is illegal. Behaviour in that case is undefined but must not corrupt other lines.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - All valid = 0, all dirty = 0.
  - d_readM = 0, d_writeM = 0, d_addressM = 0, d_dataM = Z.
  - cpu_rdata = 0 when not ready.
  - Counters = 0.
- Latency, counting the request's first cycle as cycle 0:
  - Hit: cpu_ready in cycle 0.
  - Clean miss: FILL occupies cycles 1–5; cpu_ready in cycle 6.
  - Dirty miss: EVICT occupies cycles 1–5, FILL cycles 6–10; cpu_ready in cycle 11.
- Memory alignment:
  - FILL cnt 1..4 corresponds to memory FETCH0..FETCH3.
  - EVICT cnt 1..4 corresponds to memory STORE0..STORE3.
  - Line data is valid only at FILL cnt = 4.
- Reset asserted mid-EVICT or mid-FILL:
  - Immediate abort to reset values and tri-stated bus.
  - The partially written line is discarded because valid is cleared.
- Back-to-back hits: one access per cycle, no bubbles.
- Tag/index arithmetic is unsigned. d_addressM is always a multiple of 4.

## Test plan
Memory preloaded with [0]=0x9023, [1]=0x0001, [2]=0xFFFF, [3]=0x0000. Parameter NUM_LINES = 4.

- **Cold read miss.** Reset, then read 0x0002.
  - d_readM pulses in cycle 1 with d_addressM = 0x0000.
  - cpu_ready and cpu_rdata = 0xFFFF in cycle 6.
  - miss_count = 1, access_count = 1.
- **Read hit.** Follow-up read 0x0001.
  - cpu_ready in the same cycle, cpu_rdata = 0x0001.
  - miss_count = 1, access_count = 2.
- **Write hit.** Write 0x0003 ← 0xABCD.
  - Same-cycle ready; no d_readM or d_writeM activity.
  - A subsequent read 0x0003 returns 0xABCD.
- **Dirty eviction.** Read 0x0010, which maps to index 0 with tag 1.
  - d_writeM pulses in cycle 1 with d_addressM = 0x0000 and d_dataM = 0xABCD_FFFF_0001_9023 held for cycles 1–5.
  - d_readM pulses in cycle 6 with d_addressM = 0x0010.
  - cpu_ready in cycle 11 with data 0x0000.
  - Re-reading 0x0003 then misses cleanly and returns 0xABCD.
- **Write miss allocate.** Write 0x0025 ← 0x1234 to an invalid line.
  - FILL from 0x0024, ready in cycle 6.
  - A later eviction of that line writes word 1 = 0x1234.
- **Reset mid-FILL.** Drop reset_n at FILL cnt = 2.
  - Outputs return to reset values immediately; d_dataM = Z.
  - Re-reading the same address misses again and miss_count restarts from 1.
